// File: rtl/ans_freq_table.sv
// Symbol-frequency table for the ANS codec: loads per-symbol counts, builds cumulative sums,
// validates the total, and serves encode/decode lookups. Define ANS_LOOKUP_BYPASS_EN for
// combinational (0-cycle) lookups; default is registered (1-cycle) lookups.
module ans_freq_table #(
  parameter int unsigned SYM_WIDTH = 4,
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned PROB_BITS = 7
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic [CNT_WIDTH-1:0]           cnt_in,
  input  logic                           cnt_vld,
  output logic                           cnt_rdy,
  output logic                           busy,
  output logic                           tbl_vld,
  output logic                           tbl_err,
  input  logic [SYM_WIDTH-1:0]           enc_sym,
  output logic [CNT_WIDTH-1:0]           enc_freq,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] enc_cum,
  input  logic [PROB_BITS-1:0]           dec_slot,
  output logic [SYM_WIDTH-1:0]           dec_sym,
  output logic [CNT_WIDTH-1:0]           dec_freq,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] dec_cum
);

  localparam int unsigned SymCount = 2 ** SYM_WIDTH;
  localparam int unsigned CumWidth = SYM_WIDTH + CNT_WIDTH;
  localparam int unsigned CumExt   = CumWidth + 1;
  localparam logic [CumWidth-1:0] Total = CumWidth'(1) << PROB_BITS;

  typedef enum logic [2:0] {StIdle, StLoad, StCheck, StReady, StError} state_e;

  state_e                state_q, state_d;
  logic [SYM_WIDTH-1:0]  idx_q;
  logic [CumWidth-1:0]   sum_q;
  logic [CNT_WIDTH-1:0]  freq_q [SymCount];
  logic [CumWidth-1:0]   cum_q  [SymCount];
  logic                  hs;

  assign cnt_rdy = (state_q == StLoad);
  assign busy    = (state_q == StLoad) || (state_q == StCheck);
  assign tbl_vld = (state_q == StReady);
  assign tbl_err = (state_q == StError);

  // A coincident load_start wins, so the count offered in that cycle is dropped.
  assign hs = cnt_vld & cnt_rdy & ~load_start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (hs && (&idx_q)) state_d = StCheck;
      StCheck: state_d = (sum_q == Total) ? StReady : StError;
      default: state_d = state_q;
    endcase
    if (load_start) state_d = StLoad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sum_q   <= '0;
      for (int unsigned i = 0; i < SymCount; i++) begin
        freq_q[i] <= '0;
        cum_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (load_start) begin
        idx_q <= '0;
        sum_q <= '0;
        for (int unsigned i = 0; i < SymCount; i++) begin
          freq_q[i] <= '0;
          cum_q[i]  <= '0;
        end
      end else if (hs) begin
        freq_q[idx_q] <= cnt_in;
        cum_q[idx_q]  <= sum_q;
        sum_q         <= sum_q + CumWidth'(cnt_in);
        idx_q         <= idx_q + SYM_WIDTH'(1);
      end
    end
  end

  logic [CNT_WIDTH-1:0] enc_freq_c, dec_freq_c;
  logic [CumWidth-1:0]  enc_cum_c, dec_cum_c;
  logic [SYM_WIDTH-1:0] dec_sym_c;
  logic [CumExt-1:0]    slot_ext;

  assign slot_ext = CumExt'(dec_slot);

  // Parallel range compare; intervals are disjoint so at most one entry matches.
  always_comb begin
    enc_freq_c = freq_q[enc_sym];
    enc_cum_c  = cum_q[enc_sym];
    dec_sym_c  = '0;
    dec_freq_c = '0;
    dec_cum_c  = '0;
    for (int unsigned s = 0; s < SymCount; s++) begin
      if ((freq_q[s] != '0) && (CumExt'(cum_q[s]) <= slot_ext) &&
          (slot_ext < CumExt'(cum_q[s]) + CumExt'(freq_q[s]))) begin
        dec_sym_c  = SYM_WIDTH'(s);
        dec_freq_c = freq_q[s];
        dec_cum_c  = cum_q[s];
      end
    end
  end

`ifdef ANS_LOOKUP_BYPASS_EN
  assign enc_freq = tbl_vld ? enc_freq_c : '0;
  assign enc_cum  = tbl_vld ? enc_cum_c  : '0;
  assign dec_sym  = tbl_vld ? dec_sym_c  : '0;
  assign dec_freq = tbl_vld ? dec_freq_c : '0;
  assign dec_cum  = tbl_vld ? dec_cum_c  : '0;
`else
  logic [CNT_WIDTH-1:0] enc_freq_q, dec_freq_q;
  logic [CumWidth-1:0]  enc_cum_q, dec_cum_q;
  logic [SYM_WIDTH-1:0] dec_sym_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_freq_q <= '0;
      enc_cum_q  <= '0;
      dec_sym_q  <= '0;
      dec_freq_q <= '0;
      dec_cum_q  <= '0;
    end else begin
      enc_freq_q <= enc_freq_c;
      enc_cum_q  <= enc_cum_c;
      dec_sym_q  <= dec_sym_c;
      dec_freq_q <= dec_freq_c;
      dec_cum_q  <= dec_cum_c;
    end
  end

  // Gate at the output so a stale registered result never leaks out of a load.
  assign enc_freq = tbl_vld ? enc_freq_q : '0;
  assign enc_cum  = tbl_vld ? enc_cum_q  : '0;
  assign dec_sym  = tbl_vld ? dec_sym_q  : '0;
  assign dec_freq = tbl_vld ? dec_freq_q : '0;
  assign dec_cum  = tbl_vld ? dec_cum_q  : '0;
`endif

endmodule
